// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//
// Receive-side TMDS channel decoder, one instance per channel, pixel-clock
// domain. Raw 10-bit deserializer words arrive at an arbitrary bit alignment.
// The decoder hunts for the word boundary by looking for runs of identical
// control tokens. Once locked, it decodes each symbol into either a video byte
// or a 2-bit control value.
//
// Optional feature: define TMDS_DECODER_RELOCK_CNT_EN to add the relock_count
// output. It is a saturating count of LOCKED->SEARCH transitions, used for
// link-quality debug.
//
// Parameters:
//   CTRL_RUN        consecutive identical control tokens required for lock
//   SEARCH_TIMEOUT  cycles spent at one bit offset before trying the next
//   LOCK_TIMEOUT    cycles without a control token before lock is dropped
//
// Ports:
//   clk           pixel clock, rising edge
//   rst_n         synchronous reset, active low
//   tmds_word     raw deserializer word, bit 0 received first
//   locked        word alignment established
//   offset        current alignment offset, 0..9
//   de            1: data holds a video byte, 0: control period
//   ctrl          decoded control bits {c1,c0}, held while de=1
//   data          decoded video byte, 0 while de=0
//   relock_count  (TMDS_DECODER_RELOCK_CNT_EN only) saturating relock counter
// -----------------------------------------------------------------------------
module tmds_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_word,
    output logic       locked,
    output logic [3:0] offset,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
`ifdef TMDS_DECODER_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_count
`endif
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int DWELL_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int GAP_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(CTRL_RUN);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LIMIT  = GAP_W'(LOCK_TIMEOUT);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [9:0]         prev_word_reg;
    logic [3:0]         offset_reg, offset_next;
    logic [RUN_W-1:0]   run_reg, run_next, run_inc;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [1:0]         last_tok_reg, last_tok_next;
    logic               de_reg, de_next;
    logic [1:0]         ctrl_reg, ctrl_next;
    logic [7:0]         data_reg, data_next;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
    logic [7:0]         relock_reg, relock_next;
`endif

    // The window is built from the live word and the registered previous
    // word, so an offset-0 symbol is fully contained in prev_word_reg and
    // reaches the outputs two clocks after it was presented.
    logic [19:0] window;
    logic [9:0]  cand [10];
    logic [9:0]  symbol;

    assign window = {tmds_word, prev_word_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_cand
            assign cand[gi] = window[gi+9:gi];
        end
    endgenerate

    always_comb begin
        symbol = cand[0];
        for (int i = 1; i < 10; i++) begin
            if (offset_reg == 4'(i)) begin
                symbol = cand[i];
            end
        end
    end

    // Control token recognition.
    logic       is_token;
    logic [1:0] token_val;

    always_comb begin
        is_token  = 1'b1;
        token_val = 2'b00;
        case (symbol)
            10'b1101010100: token_val = 2'b00;
            10'b0010101011: token_val = 2'b01;
            10'b0101010100: token_val = 2'b10;
            10'b1010101011: token_val = 2'b11;
            default:        is_token  = 1'b0;
        endcase
    end

    // Data symbol decode: undo the optional inversion, then undo the
    // XOR (bit 8 = 1) or XNOR (bit 8 = 0) chain.
    logic [7:0] d_word;
    logic [7:0] decoded;

    assign d_word     = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    assign decoded[0] = d_word[0];

    generate
        for (gi = 1; gi < 8; gi++) begin : g_dec
            assign decoded[gi] = symbol[8] ? (d_word[gi] ^ d_word[gi-1])
                                           : ~(d_word[gi] ^ d_word[gi-1]);
        end
    endgenerate

    // A token extends the run only if the previous symbol was the same token.
    always_comb begin
        if (!is_token) begin
            run_inc = '0;
        end else if ((run_reg != '0) && (token_val == last_tok_reg)) begin
            run_inc = run_reg + 1'b1;
        end else begin
            run_inc = RUN_W'(1);
        end
    end

    always_comb begin
        state_next    = state_reg;
        offset_next   = offset_reg;
        run_next      = run_reg;
        dwell_next    = dwell_reg;
        gap_next      = gap_reg;
        last_tok_next = last_tok_reg;
        de_next       = 1'b0;
        ctrl_next     = ctrl_reg;
        data_next     = 8'h00;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
        relock_next   = relock_reg;
`endif
        case (state_reg)
            ST_SEARCH: begin
                ctrl_next     = 2'b00;
                last_tok_next = token_val;
                // Lock qualification wins over an offset advance in the same cycle.
                if (run_inc == RUN_LOCK) begin
                    state_next = ST_LOCKED;
                    run_next   = '0;
                    dwell_next = '0;
                    gap_next   = '0;
                    ctrl_next  = token_val;
                end else if (dwell_reg == DWELL_LAST) begin
                    offset_next = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
                    run_next    = '0;
                    dwell_next  = '0;
                end else begin
                    run_next   = run_inc;
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (gap_reg == GAP_LIMIT) begin
                    // Offset is kept so the last good position is retried first.
                    state_next = ST_SEARCH;
                    run_next   = '0;
                    dwell_next = '0;
                    gap_next   = '0;
                    ctrl_next  = 2'b00;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
                    if (relock_reg != 8'hFF) begin
                        relock_next = relock_reg + 8'd1;
                    end
`endif
                end else if (is_token) begin
                    ctrl_next = token_val;
                    gap_next  = '0;
                end else begin
                    de_next   = 1'b1;
                    data_next = decoded;
                    gap_next  = gap_reg + 1'b1;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_SEARCH;
            prev_word_reg <= 10'd0;
            offset_reg    <= 4'd0;
            run_reg       <= '0;
            dwell_reg     <= '0;
            gap_reg       <= '0;
            last_tok_reg  <= 2'b00;
            de_reg        <= 1'b0;
            ctrl_reg      <= 2'b00;
            data_reg      <= 8'h00;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
            relock_reg    <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            prev_word_reg <= tmds_word;
            offset_reg    <= offset_next;
            run_reg       <= run_next;
            dwell_reg     <= dwell_next;
            gap_reg       <= gap_next;
            last_tok_reg  <= last_tok_next;
            de_reg        <= de_next;
            ctrl_reg      <= ctrl_next;
            data_reg      <= data_next;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
            relock_reg    <= relock_next;
`endif
        end
    end

    assign locked = (state_reg == ST_LOCKED);
    assign offset = offset_reg;
    assign de     = de_reg;
    assign ctrl   = ctrl_reg;
    assign data   = data_reg;
`ifdef TMDS_DECODER_RELOCK_CNT_EN
    assign relock_count = relock_reg;
`endif

endmodule
